// File: rtl/conv_frame_sequencer.sv
// rtl/conv_frame_sequencer.sv - raster-order frame sequencer for a KxK convolution datapath
//
// Accepts one frame of pixels in raster order, drives the line-buffer write
// controls, flags every complete KxK window at a stride position, delays that
// flag by the MAC latency to form output-buffer writes, and alternates between
// two output banks that the downstream layer releases.
//
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   start          one-cycle request to begin a frame
//   in_valid       input pixel present
//   in_ready       pixel accepted this cycle when in_valid is also high
//   bank_rel[1:0]  consumer pulse releasing output bank b (bit b)
//   lb_we          line-buffer write enable
//   lb_col         line-buffer column of the current pixel
//   lb_rot         rotate line-buffer rows (with the last pixel of a row)
//   win_valid      complete window present, MAC may start
//   out_we         output-buffer write enable
//   out_addr       output-buffer address, raster order
//   out_bank       bank currently being written
//   bank_full[1:0] bank holds an unconsumed frame
//   busy           sequencer not idle
//   frame_done     one-cycle pulse at frame completion
module conv_frame_sequencer #(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int K       = 3,
  parameter int STRIDE  = 1,
  parameter int MAC_LAT = 4,
  localparam int OUT_W  = (IMG_W - K) / STRIDE + 1,
  localparam int OUT_H  = (IMG_H - K) / STRIDE + 1,
  localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1,
  localparam int AW     = (OUT_W * OUT_H > 1) ? $clog2(OUT_W * OUT_H) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    bank_rel,
  output logic          lb_we,
  output logic [CW-1:0] lb_col,
  output logic          lb_rot,
  output logic          win_valid,
  output logic          out_we,
  output logic [AW-1:0] out_addr,
  output logic          out_bank,
  output logic [1:0]    bank_full,
  output logic          busy,
  output logic          frame_done
);

  localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_WIN   = CW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_WIN   = RW'(K - 1);
  localparam logic [SW-1:0] STR_LAST  = SW'(STRIDE - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(OUT_W * OUT_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic [SW-1:0]      hcnt;
  logic [SW-1:0]      vcnt;
  logic [MAC_LAT-1:0] dly;
  logic               wr_all;     // the last output address has been written
  logic               col_end;
  logic               frame_end;
  logic [1:0]         bank_full_nxt;

  assign lb_we     = in_valid & in_ready;
  assign lb_col    = col;
  assign col_end   = (col == COL_LAST);
  assign frame_end = col_end & (row == ROW_LAST);
  assign lb_rot    = lb_we & col_end;
  assign out_we    = dly[MAC_LAT-1];

  // Release first, then the completion set, so a same-cycle set wins.
  always_comb begin
    bank_full_nxt = bank_full & ~bank_rel;
    if (state == DONE) bank_full_nxt[out_bank] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      hcnt       <= '0;
      vcnt       <= '0;
      dly        <= '0;
      wr_all     <= 1'b0;
      win_valid  <= 1'b0;
      out_addr   <= '0;
      out_bank   <= 1'b0;
      bank_full  <= 2'b00;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid <= 1'b0;
      bank_full <= bank_full_nxt;

      // MAC latency model runs in every state so in-flight results drain.
      dly[0] <= win_valid;
      for (int i = 1; i < MAC_LAT; i++) dly[i] <= dly[i-1];

      if (out_we) begin
        if (out_addr == ADDR_LAST) wr_all <= 1'b1;
        else                       out_addr <= out_addr + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start && !bank_full[out_bank]) begin
            state    <= RUN;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            col      <= '0;
            row      <= '0;
            hcnt     <= '0;
            vcnt     <= '0;
            out_addr <= '0;
            wr_all   <= 1'b0;
          end
        end

        RUN: begin
          if (lb_we) begin
            win_valid <= (row >= ROW_WIN) && (col >= COL_WIN) &&
                         (hcnt == '0) && (vcnt == '0);
            if (col_end) begin
              col  <= '0;
              hcnt <= '0;
              if (frame_end) begin
                row      <= '0;
                vcnt     <= '0;
                state    <= FLUSH;
                in_ready <= 1'b0;
              end else begin
                row <= row + 1'b1;
                if (row >= ROW_WIN) vcnt <= (vcnt == STR_LAST) ? '0 : vcnt + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
              if (col >= COL_WIN) hcnt <= (hcnt == STR_LAST) ? '0 : hcnt + 1'b1;
            end
          end
        end

        FLUSH: begin
          if (wr_all && !win_valid && (dly == '0)) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end

        DONE: begin
          state      <= IDLE;
          frame_done <= 1'b0;
          busy       <= 1'b0;
          out_bank   <= ~out_bank;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// tb/tb_conv_frame_sequencer.sv - directed bench for conv_frame_sequencer on 5x5 frames
module tb_conv_frame_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, in_valid, sel;
  logic [1:0] bank_rel;
  logic       start_a, start_b;
  logic [1:0] rel_a, rel_b;

  logic       a_in_ready, a_lb_we, a_lb_rot, a_win_valid, a_out_we, a_out_bank, a_busy, a_frame_done;
  logic [2:0] a_lb_col;
  logic [3:0] a_out_addr;
  logic [1:0] a_bank_full;
  logic       b_in_ready, b_lb_we, b_lb_rot, b_win_valid, b_out_we, b_out_bank, b_busy, b_frame_done;
  logic [2:0] b_lb_col;
  logic [1:0] b_out_addr;
  logic [1:0] b_bank_full;

  logic       o_in_ready, o_lb_we, o_lb_rot, o_win_valid, o_out_we, o_out_bank, o_busy, o_frame_done;
  logic [2:0] o_lb_col;
  logic [3:0] o_out_addr;
  logic [1:0] o_bank_full;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign rel_a   = sel ? 2'b00 : bank_rel;
  assign rel_b   = sel ? bank_rel : 2'b00;

  assign o_in_ready   = sel ? b_in_ready   : a_in_ready;
  assign o_lb_we      = sel ? b_lb_we      : a_lb_we;
  assign o_lb_rot     = sel ? b_lb_rot     : a_lb_rot;
  assign o_win_valid  = sel ? b_win_valid  : a_win_valid;
  assign o_out_we     = sel ? b_out_we     : a_out_we;
  assign o_out_bank   = sel ? b_out_bank   : a_out_bank;
  assign o_busy       = sel ? b_busy       : a_busy;
  assign o_frame_done = sel ? b_frame_done : a_frame_done;
  assign o_lb_col     = sel ? b_lb_col     : a_lb_col;
  assign o_out_addr   = sel ? {2'b00, b_out_addr} : a_out_addr;
  assign o_bank_full  = sel ? b_bank_full  : a_bank_full;

  conv_frame_sequencer #(.IMG_W(5), .IMG_H(5), .K(3), .STRIDE(1), .MAC_LAT(4)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .in_valid(in_valid), .in_ready(a_in_ready),
    .bank_rel(rel_a), .lb_we(a_lb_we), .lb_col(a_lb_col), .lb_rot(a_lb_rot),
    .win_valid(a_win_valid), .out_we(a_out_we), .out_addr(a_out_addr), .out_bank(a_out_bank),
    .bank_full(a_bank_full), .busy(a_busy), .frame_done(a_frame_done)
  );

  conv_frame_sequencer #(.IMG_W(5), .IMG_H(5), .K(3), .STRIDE(2), .MAC_LAT(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .in_valid(in_valid), .in_ready(b_in_ready),
    .bank_rel(rel_b), .lb_we(b_lb_we), .lb_col(b_lb_col), .lb_rot(b_lb_rot),
    .win_valid(b_win_valid), .out_we(b_out_we), .out_addr(b_out_addr), .out_bank(b_out_bank),
    .bank_full(b_bank_full), .busy(b_busy), .frame_done(b_frame_done)
  );

  int total = 0;
  int bad = 0;

  int win_idx[$];
  int win_cyc[$];
  int we_addr[$];
  int we_cyc[$];
  int rot_cnt, done_cnt, acc_cnt, col_err, we_bank;

  // Runs one frame on the selected DUT and records what it did, cycle by cycle.
  task automatic run_frame(input bit toggle, input bit disturb, input logic [1:0] rel_at_done);
    int cyc, acc, prev_idx;
    bit prev_acc, finished;
    win_idx.delete(); win_cyc.delete(); we_addr.delete(); we_cyc.delete();
    rot_cnt = 0; done_cnt = 0; col_err = 0; we_bank = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0; acc = 0; prev_acc = 1'b0; prev_idx = -1; finished = 1'b0;
    while (!finished && cyc < 400) begin
      bank_rel = 2'b00;
      if (o_win_valid) begin
        win_idx.push_back(prev_acc ? prev_idx : -1);
        win_cyc.push_back(cyc);
      end
      if (o_out_we) begin
        we_addr.push_back(int'(o_out_addr));
        we_cyc.push_back(cyc);
        we_bank = int'(o_out_bank);
      end
      if (o_frame_done) begin
        done_cnt++;
        finished = 1'b1;
        bank_rel = rel_at_done;
      end
      if (acc < 25) in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      else          in_valid = disturb;
      start = disturb && (acc == 7);
      #1;
      prev_acc = o_lb_we;
      if (o_lb_we) begin
        if (int'(o_lb_col) != acc % 5) col_err++;
        prev_idx = acc;
        acc++;
      end
      if (o_lb_rot) rot_cnt++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; start = 1'b0; bank_rel = 2'b00;
    total++;
    if (!finished) begin
      bad++;
      $display("FAIL frame_timeout: no frame_done within %0d cycles, want one", cyc);
    end
    repeat (4) begin
      if (o_frame_done) done_cnt++;
      @(negedge clk);
    end
    acc_cnt = acc;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b1; bank_rel = 2'b00; sel = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({a_in_ready, a_lb_we, a_lb_rot, a_win_valid, a_out_we, a_out_bank, a_busy, a_frame_done} !== 8'h00) begin
      bad++;
      $display("FAIL reset_ctrl_a: got %b want 00000000",
               {a_in_ready, a_lb_we, a_lb_rot, a_win_valid, a_out_we, a_out_bank, a_busy, a_frame_done});
    end
    total++;
    if ({a_out_addr, a_bank_full, a_lb_col} !== 9'h000) begin
      bad++;
      $display("FAIL reset_data_a: got addr=%0d full=%b col=%0d want 0/00/0", a_out_addr, a_bank_full, a_lb_col);
    end
    total++;
    if ({b_in_ready, b_busy, b_out_addr, b_bank_full, b_out_bank, b_lb_we} !== 8'h00) begin
      bad++;
      $display("FAIL reset_b: got %b want 00000000", {b_in_ready, b_busy, b_out_addr, b_bank_full, b_out_bank, b_lb_we});
    end
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({a_lb_we, a_busy, a_in_ready} !== 3'b000) begin
      bad++;
      $display("FAIL idle_in_valid: got lb_we/busy/in_ready=%b want 000", {a_lb_we, a_busy, a_in_ready});
    end
    in_valid = 1'b0;
  endtask

  task automatic test_full_frame();
    int exp_win[9] = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
    run_frame(1'b0, 1'b0, 2'b00);
    total++;
    if (win_idx.size() != 9) begin
      bad++;
      $display("FAIL full_win_count: got %0d want 9", win_idx.size());
    end
    for (int k = 0; k < 9; k++) begin
      total++;
      if (k >= win_idx.size() || win_idx[k] != exp_win[k]) begin
        bad++;
        $display("FAIL full_win_%0d: after pixel %0d want after pixel %0d", k, (k < win_idx.size()) ? win_idx[k] : -1, exp_win[k]);
      end
    end
    for (int k = 0; k < 9; k++) begin
      total++;
      if (k >= we_addr.size() || k >= win_cyc.size() || we_addr[k] != k || we_cyc[k] - win_cyc[k] != 4) begin
        bad++;
        $display("FAIL full_out_%0d: got addr=%0d delay=%0d want addr=%0d delay=4", k,
                 (k < we_addr.size()) ? we_addr[k] : -1,
                 (k < we_cyc.size() && k < win_cyc.size()) ? we_cyc[k] - win_cyc[k] : -1, k);
      end
    end
    total++;
    if (we_addr.size() != 9 || col_err != 0 || rot_cnt != 5) begin
      bad++;
      $display("FAIL full_misc: got writes=%0d col_err=%0d rot=%0d want 9/0/5", we_addr.size(), col_err, rot_cnt);
    end
    total++;
    if (done_cnt != 1 || o_bank_full !== 2'b01 || o_out_bank !== 1'b1 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL full_end: got done=%0d full=%b bank=%b busy=%b want 1/01/1/0", done_cnt, o_bank_full, o_out_bank, o_busy);
    end
  endtask

  task automatic test_toggle();
    int exp_win[9] = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
    int miss;
    run_frame(1'b1, 1'b0, 2'b00);
    miss = 0;
    for (int k = 0; k < win_idx.size(); k++) if (k >= 9 || win_idx[k] != exp_win[k]) miss++;
    total++;
    if (miss != 0 || win_idx.size() != 9) begin
      bad++;
      $display("FAIL toggle_win_seq: got %0d pulses with %0d misplaced want 9 with 0", win_idx.size(), miss);
    end
    miss = 0;
    for (int k = 0; k < we_addr.size(); k++)
      if (we_addr[k] != k || k >= win_cyc.size() || we_cyc[k] - win_cyc[k] != 4) miss++;
    total++;
    if (miss != 0 || we_addr.size() != 9) begin
      bad++;
      $display("FAIL toggle_out_seq: got %0d writes with %0d wrong want 9 with 0", we_addr.size(), miss);
    end
    total++;
    if (rot_cnt != 5 || col_err != 0) begin
      bad++;
      $display("FAIL toggle_rot: got rot=%0d col_err=%0d want 5/0", rot_cnt, col_err);
    end
    total++;
    if (we_bank != 1 || o_bank_full !== 2'b11 || o_out_bank !== 1'b0) begin
      bad++;
      $display("FAIL toggle_bank: got wr_bank=%0d full=%b bank=%b want 1/11/0", we_bank, o_bank_full, o_out_bank);
    end
  endtask

  task automatic test_pingpong();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (o_busy !== 1'b0 || o_in_ready !== 1'b0) begin
      bad++;
      $display("FAIL pp_start_dropped: got busy=%b in_ready=%b want 0/0", o_busy, o_in_ready);
    end
    bank_rel = 2'b01;
    @(negedge clk); bank_rel = 2'b00;
    total++;
    if (o_bank_full !== 2'b10) begin
      bad++;
      $display("FAIL pp_release0: got full=%b want 10", o_bank_full);
    end
    run_frame(1'b0, 1'b0, 2'b01);
    total++;
    if (we_addr.size() != 9 || we_bank != 0) begin
      bad++;
      $display("FAIL pp_frame_bank0: got writes=%0d bank=%0d want 9/0", we_addr.size(), we_bank);
    end
    total++;
    if (o_bank_full !== 2'b11 || o_out_bank !== 1'b1) begin
      bad++;
      $display("FAIL pp_set_wins: got full=%b bank=%b want 11/1", o_bank_full, o_out_bank);
    end
    bank_rel = 2'b11;
    @(negedge clk); bank_rel = 2'b00;
    total++;
    if (o_bank_full !== 2'b00) begin
      bad++;
      $display("FAIL pp_release_both: got full=%b want 00", o_bank_full);
    end
    bank_rel = 2'b01;
    @(negedge clk); bank_rel = 2'b00;
    total++;
    if (o_bank_full !== 2'b00) begin
      bad++;
      $display("FAIL pp_release_empty: got full=%b want 00", o_bank_full);
    end
  endtask

  task automatic test_disturb();
    int exp_win[9] = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
    int miss;
    run_frame(1'b0, 1'b1, 2'b00);
    miss = 0;
    for (int k = 0; k < win_idx.size(); k++) if (k >= 9 || win_idx[k] != exp_win[k]) miss++;
    total++;
    if (miss != 0 || win_idx.size() != 9) begin
      bad++;
      $display("FAIL disturb_win_seq: got %0d pulses with %0d misplaced want 9 with 0", win_idx.size(), miss);
    end
    total++;
    if (acc_cnt != 25 || col_err != 0) begin
      bad++;
      $display("FAIL disturb_accepts: got %0d accepts col_err=%0d want 25/0", acc_cnt, col_err);
    end
    miss = 0;
    for (int k = 0; k < we_addr.size(); k++) if (we_addr[k] != k) miss++;
    total++;
    if (miss != 0 || we_addr.size() != 9 || we_bank != 1) begin
      bad++;
      $display("FAIL disturb_out: got %0d writes %0d wrong bank=%0d want 9/0/1", we_addr.size(), miss, we_bank);
    end
    total++;
    if (o_bank_full !== 2'b10 || o_out_bank !== 1'b0 || done_cnt != 1) begin
      bad++;
      $display("FAIL disturb_end: got full=%b bank=%b done=%0d want 10/0/1", o_bank_full, o_out_bank, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int miss;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; in_valid = 1'b1;
    repeat (11) @(negedge clk);
    total++;
    if (o_busy !== 1'b1 || o_in_ready !== 1'b1 || o_lb_col !== 3'd1) begin
      bad++;
      $display("FAIL mid_precondition: got busy=%b in_ready=%b col=%0d want 1/1/1", o_busy, o_in_ready, o_lb_col);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({o_in_ready, o_lb_we, o_lb_rot, o_win_valid, o_out_we, o_out_bank, o_busy, o_frame_done} !== 8'h00 ||
        o_out_addr !== 4'd0 || o_bank_full !== 2'b00 || o_lb_col !== 3'd0) begin
      bad++;
      $display("FAIL mid_reset_clear: got ctrl=%b addr=%0d full=%b col=%0d want all zero",
               {o_in_ready, o_lb_we, o_lb_rot, o_win_valid, o_out_we, o_out_bank, o_busy, o_frame_done},
               o_out_addr, o_bank_full, o_lb_col);
    end
    @(negedge clk); reset = 1'b0; in_valid = 1'b0;
    run_frame(1'b0, 1'b0, 2'b00);
    miss = 0;
    for (int k = 0; k < we_addr.size(); k++) if (we_addr[k] != k) miss++;
    total++;
    if (miss != 0 || we_addr.size() != 9 || we_bank != 0) begin
      bad++;
      $display("FAIL mid_new_frame: got %0d writes %0d wrong bank=%0d want 9/0/0", we_addr.size(), miss, we_bank);
    end
    total++;
    if (o_bank_full !== 2'b01 || o_out_bank !== 1'b1) begin
      bad++;
      $display("FAIL mid_end: got full=%b bank=%b want 01/1", o_bank_full, o_out_bank);
    end
  endtask

  task automatic test_stride2();
    int exp_win[4] = '{12, 14, 22, 24};
    int miss;
    sel = 1'b1;
    run_frame(1'b0, 1'b0, 2'b00);
    miss = 0;
    for (int k = 0; k < win_idx.size(); k++) if (k >= 4 || win_idx[k] != exp_win[k]) miss++;
    total++;
    if (miss != 0 || win_idx.size() != 4) begin
      bad++;
      $display("FAIL s2_win_seq: got %0d pulses with %0d misplaced want 4 with 0", win_idx.size(), miss);
    end
    miss = 0;
    for (int k = 0; k < we_addr.size(); k++)
      if (we_addr[k] != k || k >= win_cyc.size() || we_cyc[k] - win_cyc[k] != 4) miss++;
    total++;
    if (miss != 0 || we_addr.size() != 4) begin
      bad++;
      $display("FAIL s2_out_seq: got %0d writes with %0d wrong want 4 with 0", we_addr.size(), miss);
    end
    total++;
    if (o_bank_full !== 2'b01 || o_out_bank !== 1'b1 || done_cnt != 1) begin
      bad++;
      $display("FAIL s2_end: got full=%b bank=%b done=%0d want 01/1/1", o_bank_full, o_out_bank, done_cnt);
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_toggle();
    test_pingpong();
    test_disturb();
    test_reset_mid();
    test_stride2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish within 300000 time units");
    $fatal(1);
  end

endmodule

// File: doc/conv_frame_sequencer.md
Name: conv_frame_sequencer

Overview:
- Sequences one convolution datapath over a streamed input frame.
- Accepts pixels in raster order, drives the line-buffer write controls, and raises the window-valid strobe whenever a complete KxK window at a stride position is present.
- Delays that strobe by the MAC pipeline latency to form output-buffer writes, and manages a ping-pong pair of output banks shared with the downstream layer.

Parameters:
- IMG_W, 28, input frame width in pixels (>= K)
- IMG_H, 28, input frame height in pixels (>= K)
- K, 3, kernel size
- STRIDE, 1, window stride in both dimensions (>= 1)
- MAC_LAT, 4, cycles from win_valid to result ready at datapath output (>= 1)
- OUT_W/OUT_H, derived, (IMG_W-K)/STRIDE+1 and (IMG_H-K)/STRIDE+1; not overridable
- CW/RW/AW, derived, $clog2(IMG_W), $clog2(IMG_H), $clog2(OUT_W*OUT_H)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request to begin a frame
- in_valid  input  1  input pixel present
- in_ready  output  1  sequencer accepts pixel this cycle
- bank_rel  input  2  consumer pulse releasing output bank b (bit b)
- lb_we  output  1  line-buffer write enable (= in_valid & in_ready)
- lb_col  output  CW  line-buffer column address of current pixel
- lb_rot  output  1  rotate line-buffer rows (asserted with the accept of col IMG_W-1)
- win_valid  output  1  registered: datapath window is complete, MAC may start
- out_we  output  1  output-buffer write enable
- out_addr  output  AW  output-buffer address (raster order)
- out_bank  output  1  bank currently being written
- bank_full  output  2  bank holds an unconsumed frame
- busy  output  1  state != IDLE
- frame_done  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset values: all outputs 0; state IDLE; col, row, stride counters, out_addr and delay line cleared; out_bank=0; bank_full=2'b00.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - If start=1 and bank_full[out_bank]=0: go to RUN and clear col, row, out_addr and stride counters.
  - If start=1 with the target bank full, the start is dropped and the state stays IDLE.
- RUN:
  - in_ready=1. A pixel is accepted on in_valid=1. No accept means all counters hold.
  - On accept: col increments. At IMG_W-1, col wraps to 0, row increments, and lb_rot=1 in the same cycle.
  - Horizontal stride counter: resets to 0 when col wraps; counts 0..STRIDE-1 once col >= K-1. The vertical stride counter works the same way on row.
  - Next cycle, win_valid=1 iff the accepted pixel had row>=K-1, col>=K-1 and both stride counters were 0.
  - Accepting pixel (IMG_H-1, IMG_W-1) moves to FLUSH. in_ready=0 from the next cycle.
- Delay line: MAC_LAT-stage shift register of win_valid, running in every state. out_we is the last stage. out_addr increments after each out_we and never exceeds OUT_W*OUT_H-1.
- FLUSH:
  - in_ready=0.
  - When out_addr has counted OUT_W*OUT_H writes and no win_valid remains in the delay line, go to DONE.
- DONE (one cycle):
  - frame_done=1, bank_full[out_bank]<=1, out_bank toggles, then go to IDLE.
- bank_rel[b] clears bank_full[b]:
  - Release of a non-full bank: no effect.
  - Release and set of the same bank in the same cycle: set wins.
  - Both bits may be released in one cycle.
- start in RUN, FLUSH or DONE is ignored.
- in_valid outside RUN is ignored (lb_we=0).
- Asynchronous reset mid-frame aborts immediately. All state returns to reset values and partial output is discarded (bank_full unchanged from reset, i.e. 0).
- Latency: first win_valid 1 cycle after accept of pixel (K-1,K-1). The matching out_we follows MAC_LAT cycles later.

Test Plan:
1. IMG_W=IMG_H=5, K=3, STRIDE=1, MAC_LAT=4, start, in_valid held 1 for 25 cycles.
   - 9 win_valid pulses, 1 cycle after accepts 12,13,14,17,18,19,22,23,24 (0-based).
   - out_addr 0..8 on out_we.
   - frame_done once, bank_full=01, out_bank=1.
2. Same config with in_valid toggling every other cycle.
   - Identical win_valid/out_addr sequence with no counter advance on idle cycles.
   - lb_rot exactly 5 times.
3. STRIDE=2, IMG 5x5:
   - win_valid only after pixels (2,2),(2,4),(4,2),(4,4).
   - 4 out_we, addresses 0..3.
4. Ping-pong:
   - Run two frames without release: bank_full=11.
   - A third start leaves busy=0.
   - Pulse bank_rel=01, then start: the frame writes bank 0.
   - Same-cycle set/release on bank 0 leaves bank_full[0]=1.
5. Assert reset while row=2 in RUN.
   - All outputs 0 and state IDLE immediately.
   - A new start then produces a full 9-output frame into bank 0.
6. start pulsed during RUN and in_valid during FLUSH.
   - No effect on counters or lb_we.
